// File: rtl/fetch_stage_r32i_if.sv
// Instruction-memory request/ack bus and decoder-side valid/ready bus of the RV32I fetch stage.
// Handshakes: InsReq stays high with InsAddr stable until the one-cycle InsAck pulse retires it; the head entry transfers when InsValid && InsReady.
interface fetch_stage_r32i_if #(
  parameter int dataW = 32
);
  logic [dataW-1:0] InsAddr;
  logic             InsReq;
  logic             InsAck;
  logic [dataW-1:0] InsData;
  logic [dataW-1:0] rawIns;
  logic [dataW-1:0] ProgAddr;
  logic             InsValid;
  logic             InsReady;

  modport master (
    output InsAddr, InsReq, rawIns, ProgAddr, InsValid,
    input  InsAck, InsData, InsReady
  );

  modport slave (
    input  InsAddr, InsReq, rawIns, ProgAddr, InsValid,
    output InsAck, InsData, InsReady
  );
endinterface

// File: rtl/fetch_stage_r32i.sv
// RV32I fetch stage: owns the fetch PC, issues word reads, and buffers up to two
// {instruction, address} entries for the decoder; branches redirect and flush.
module fetch_stage_r32i #(
  parameter int               dataW    = 32,
  parameter logic [dataW-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  fetch_stage_r32i_if.master bus,
  input  logic               Branch,
  input  logic [dataW-1:0]   BranchTarget,
  output logic               MisalignFault,
  output logic [1:0]         fsm_state
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD, S_HALT} state_t;

  state_t           state;
  logic [dataW-1:0] fpc;
  logic [dataW-1:0] buf_ins  [2];
  logic [dataW-1:0] buf_addr [2];
  logic [1:0]       count;

  logic             push, pop, stale_wait, target_ok, can_issue, fault_next, slot;
  logic [1:0]       count_next;
  logic [dataW-1:0] fpc_next;

  assign target_ok  = (BranchTarget[1:0] == 2'b00);
  assign pop        = (count != 2'd0) && bus.InsReady;
  assign push       = (state == S_WAIT) && bus.InsAck && !Branch;
  assign stale_wait = ((state == S_WAIT) || (state == S_DISCARD)) && !bus.InsAck;
  // Push lands behind whatever survives this cycle's pop.
  assign slot       = (count == 2'd2) || ((count == 2'd1) && !pop);
  assign can_issue  = !stale_wait && !fault_next && (count_next != 2'd2);

  always_comb begin
    count_next = count;
    if (Branch)
      count_next = 2'd0;
    else if (push && !pop)
      count_next = count + 2'd1;
    else if (pop && !push)
      count_next = count - 2'd1;

    fpc_next   = fpc;
    fault_next = MisalignFault;
    if (Branch) begin
      if (target_ok) begin
        fpc_next   = BranchTarget;
        fault_next = 1'b0;
      end else begin
        fault_next = 1'b1;
      end
    end else if (push) begin
      fpc_next = fpc + dataW'(4);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      fpc           <= RESET_PC;
      count         <= 2'd0;
      MisalignFault <= 1'b0;
      bus.InsReq    <= 1'b0;
      bus.InsAddr   <= RESET_PC;
      buf_ins[0]    <= '0;
      buf_ins[1]    <= '0;
      buf_addr[0]   <= '0;
      buf_addr[1]   <= '0;
    end else begin
      fpc           <= fpc_next;
      count         <= count_next;
      MisalignFault <= fault_next;

      if (!Branch) begin
        if (pop) begin
          buf_ins[0]  <= buf_ins[1];
          buf_addr[0] <= buf_addr[1];
        end
        if (push) begin
          buf_ins[slot]  <= bus.InsData;
          buf_addr[slot] <= bus.InsAddr;
        end
      end

      // A request still in flight keeps its address; a redirect only marks its data stale.
      if (can_issue) begin
        state       <= S_WAIT;
        bus.InsReq  <= 1'b1;
        bus.InsAddr <= fpc_next;
      end else if (stale_wait) begin
        state <= ((state == S_WAIT) && !Branch) ? S_WAIT : S_DISCARD;
      end else begin
        bus.InsReq <= 1'b0;
        state      <= fault_next ? S_HALT : S_IDLE;
      end
    end
  end

  assign bus.rawIns   = buf_ins[0];
  assign bus.ProgAddr = buf_addr[0];
  assign bus.InsValid = (count != 2'd0);
  assign fsm_state    = state;
endmodule
